// File: rtl/crc_pkg.sv
// Shared types and helpers for the CRC engine scheduler: FSM states, widths
// and the round-robin pick function used by the arbiter.
package crc_pkg;

  localparam int CRC_W   = 16;
  localparam int BYTE_W  = 8;
  localparam int MAX_REQ = 8;
  localparam int PTR_W   = 3;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    FEED,
    WAIT,
    DONE
  } state_e;

  // Scan from ptr+1 (mod n) upward. The loop runs from the farthest candidate
  // back to the nearest, so the nearest requesting index wins.
  // Returns ptr unchanged when no bit of req is set.
  function automatic logic [PTR_W-1:0] rr_pick(input logic [MAX_REQ-1:0] req,
                                               input logic [PTR_W-1:0]   ptr,
                                               input int                 n);
    logic [PTR_W-1:0] pick;
    int               cand;
    pick = ptr;
    for (int k = MAX_REQ; k >= 1; k--) begin
      if (k <= n) begin
        cand = (int'(ptr) + k) % n;
        if (req[cand[PTR_W-1:0]]) pick = cand[PTR_W-1:0];
      end
    end
    return pick;
  endfunction

endpackage

// File: rtl/crc_engine_scheduler_rr_arbiter.sv
// Round-robin arbiter: combinational pick from the pointer register, and a
// pointer update to the picked index when the caller accepts the pick.
module rr_arbiter
  import crc_pkg::*;
#(
  parameter int N_REQ = 4
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic [N_REQ-1:0]                      req,
  input  logic                                  advance,
  output logic [((N_REQ > 1) ? $clog2(N_REQ) : 1)-1:0] pick_idx,
  output logic                                  pick_valid
);

  localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  logic [IDX_W-1:0] ptr_q, ptr_d;

  always_comb begin
    pick_idx   = IDX_W'(rr_pick(MAX_REQ'(req), PTR_W'(ptr_q), N_REQ));
    pick_valid = |req;
    ptr_d      = advance ? pick_idx : ptr_q;
  end

  // Reset to the last index so that requester 0 is the first one scanned.
  always_ff @(posedge clk) begin
    if (rst) ptr_q <= IDX_W'(N_REQ - 1);
    else     ptr_q <= ptr_d;
  end

endmodule

// File: rtl/crc_engine_scheduler.sv
// Shares one external CRC16D8 byte engine among N_REQ word requesters:
// grant, seed the engine, feed the word MSB byte first, return the CRC.
module crc_engine_scheduler
  import crc_pkg::*;
#(
  parameter int N_REQ  = 4,
  parameter int DATA_W = 64
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [N_REQ-1:0]          req,
  input  logic [N_REQ*DATA_W-1:0]   data_in,
  output logic [N_REQ-1:0]          gnt,
  output logic [N_REQ-1:0]          done,
  output logic [CRC_W-1:0]          crc_out,
  output logic                      busy,
  output logic                      eng_rst,
  output logic                      eng_en,
  output logic [BYTE_W-1:0]         eng_byte,
  input  logic [CRC_W-1:0]          eng_crc
);

  localparam int NBYTES = DATA_W / BYTE_W;
  localparam int IDX_W  = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int BCNT_W = $clog2(NBYTES + 1);

  state_e             state_q, state_d;
  logic [DATA_W-1:0]  shift_q, shift_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [BCNT_W-1:0]  bcnt_q, bcnt_d;
  logic [CRC_W-1:0]   crc_q, crc_d;
  logic [BYTE_W-1:0]  last_byte_q, last_byte_d;

  logic [IDX_W-1:0]   arb_idx;
  logic               arb_valid;
  logic               arb_advance;

  rr_arbiter #(.N_REQ(N_REQ)) u_rr_arbiter (
    .clk        (clk),
    .rst        (rst),
    .req        (req),
    .advance    (arb_advance),
    .pick_idx   (arb_idx),
    .pick_valid (arb_valid)
  );

  // NOTE: every output and next-state value gets a default before the case
  // statement, so no path through this block can leave a latch behind.
  always_comb begin
    state_d     = state_q;
    shift_d     = shift_q;
    idx_d       = idx_q;
    bcnt_d      = bcnt_q;
    crc_d       = crc_q;
    last_byte_d = last_byte_q;
    gnt         = '0;
    done        = '0;
    eng_rst     = 1'b0;
    eng_en      = 1'b0;
    eng_byte    = last_byte_q;
    arb_advance = 1'b0;

    unique case (state_q)
      IDLE: begin
        // Suppress the grant while rst is high: the job would be lost anyway.
        if (arb_valid && !rst) begin
          gnt[arb_idx] = 1'b1;
          shift_d      = data_in[arb_idx*DATA_W +: DATA_W];
          idx_d        = arb_idx;
          arb_advance  = 1'b1;
          state_d      = LOAD;
        end
      end
      LOAD: begin
        eng_rst = 1'b1;
        bcnt_d  = '0;
        state_d = FEED;
      end
      FEED: begin
        eng_en      = 1'b1;
        eng_byte    = shift_q[DATA_W-1 -: BYTE_W];
        last_byte_d = shift_q[DATA_W-1 -: BYTE_W];
        shift_d     = shift_q << BYTE_W;
        bcnt_d      = bcnt_q + BCNT_W'(1);
        if (bcnt_q == BCNT_W'(NBYTES - 1)) state_d = WAIT;
      end
      WAIT: begin
        state_d = DONE;
      end
      DONE: begin
        crc_d       = eng_crc;
        done[idx_q] = 1'b1;
        state_d     = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the values computed before this clock edge, whatever the block order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      shift_q     <= '0;
      idx_q       <= '0;
      bcnt_q      <= '0;
      crc_q       <= '0;
      last_byte_q <= '0;
    end else begin
      state_q     <= state_d;
      shift_q     <= shift_d;
      idx_q       <= idx_d;
      bcnt_q      <= bcnt_d;
      crc_q       <= crc_d;
      last_byte_q <= last_byte_d;
    end
  end

  assign crc_out = crc_q;
  assign busy    = (state_q != IDLE);

endmodule

// File: tb/tb_crc_engine_scheduler.sv
// Self-checking bench for crc_engine_scheduler with a behavioural CRC16D8
// engine (CCITT 0x1021, seed 0xFFFF) and a grant/done/crc scoreboard.
module tb_crc_engine_scheduler;

  localparam int N_REQ  = 4;
  localparam int DATA_W = 64;
  localparam int NBYTES = DATA_W / 8;
  localparam int LAT    = NBYTES + 3;
  localparam int PERIOD = NBYTES + 4;

  logic                    clk = 1'b0;
  logic                    rst;
  logic [N_REQ-1:0]        req;
  logic [N_REQ*DATA_W-1:0] data_in;
  logic [N_REQ-1:0]        gnt;
  logic [N_REQ-1:0]        done;
  logic [15:0]             crc_out;
  logic                    busy;
  logic                    eng_rst;
  logic                    eng_en;
  logic [7:0]              eng_byte;
  logic [15:0]             eng_crc;

  crc_engine_scheduler #(.N_REQ(N_REQ), .DATA_W(DATA_W)) dut (
    .clk      (clk),
    .rst      (rst),
    .req      (req),
    .data_in  (data_in),
    .gnt      (gnt),
    .done     (done),
    .crc_out  (crc_out),
    .busy     (busy),
    .eng_rst  (eng_rst),
    .eng_en   (eng_en),
    .eng_byte (eng_byte),
    .eng_crc  (eng_crc)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] crc_byte(input logic [15:0] c, input logic [7:0] b);
    logic [15:0] r;
    r = c ^ {b, 8'h00};
    for (int k = 0; k < 8; k++) r = r[15] ? ((r << 1) ^ 16'h1021) : (r << 1);
    return r;
  endfunction

  function automatic logic [15:0] golden(input logic [63:0] w);
    logic [15:0] c;
    c = 16'hFFFF;
    for (int k = 0; k < NBYTES; k++) c = crc_byte(c, w[63-8*k -: 8]);
    return c;
  endfunction

  function automatic int first_idx(input logic [N_REQ-1:0] v);
    int r;
    r = 0;
    for (int k = N_REQ - 1; k >= 0; k--) if (v[k]) r = k;
    return r;
  endfunction

  // Behavioural CRC16D8: registered CRC, seeded by eng_rst.
  always @(posedge clk) begin
    if (rst)          eng_crc <= 16'h0000;
    else if (eng_rst) eng_crc <= 16'hFFFF;
    else if (eng_en)  eng_crc <= crc_byte(eng_crc, eng_byte);
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { logic [N_REQ-1:0] vec; int cyc; logic [15:0] crc; } gnt_rec_t;
  typedef struct { logic [N_REQ-1:0] vec; int cyc; } done_rec_t;
  typedef struct { logic [7:0] b; int cyc; } byte_rec_t;

  gnt_rec_t   gnt_q[$];
  done_rec_t  done_q[$];
  logic [15:0] crc_q[$];
  byte_rec_t  byte_q[$];
  int         overlap_cnt = 0;
  logic       done_prev = 1'b0;

  // Monitor: expectations are pushed when a word is granted, results when the
  // DUT reports done; crc_out is taken in the cycle after done.
  always @(negedge clk) begin
    if (done_prev) crc_q.push_back(crc_out);
    done_prev <= (|done) && !rst;
    if (|gnt) gnt_q.push_back('{gnt, cyc, golden(data_in[first_idx(gnt)*DATA_W +: DATA_W])});
    if (|done) done_q.push_back('{done, cyc});
    if (eng_en) byte_q.push_back('{eng_byte, cyc});
    if (eng_rst && eng_en) overlap_cnt <= overlap_cnt + 1;
  end

  int checks = 0;
  int errors = 0;
  int gnt_rd = 0, done_rd = 0, crc_rd = 0, byte_rd = 0;
  int exp_q[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic timeout(input string name);
    checks++;
    errors++;
    $display("FAIL %s timeout", name);
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_grants(input int n, input int budget);
    int c = 0;
    while ((gnt_q.size() - gnt_rd) < n && c < budget) begin tick(1); c++; end
    if ((gnt_q.size() - gnt_rd) < n) timeout("wait_grants");
  endtask

  task automatic wait_idle(input int budget);
    int c = 0;
    while (busy && c < budget) begin tick(1); c++; end
    if (busy) timeout("wait_idle");
    tick(2);
  endtask

  task automatic set_word(input int i, input logic [63:0] w);
    data_in[i*DATA_W +: DATA_W] = w;
  endtask

  // Check all jobs logged since the last call against exp_q (grant order).
  task automatic check_jobs(input bit spaced);
    int n_g;
    n_g = gnt_q.size() - gnt_rd;
    check("grant_count", 64'(n_g), 64'(exp_q.size()));
    check("done_count", 64'(done_q.size() - done_rd), 64'(n_g));
    for (int i = 0; i < n_g; i++) begin
      gnt_rec_t g;
      g = gnt_q[gnt_rd + i];
      if (i < exp_q.size()) check("grant_order", 64'(g.vec), 64'(1 << exp_q[i]));
      if (spaced && i > 0) check("grant_spacing", 64'(g.cyc - gnt_q[gnt_rd + i - 1].cyc), 64'(PERIOD));
      if (done_rd + i < done_q.size()) begin
        check("done_index", 64'(done_q[done_rd + i].vec), 64'(g.vec));
        check("done_latency", 64'(done_q[done_rd + i].cyc - g.cyc), 64'(LAT));
      end
      if (crc_rd + i < crc_q.size()) check("crc_value", 64'(crc_q[crc_rd + i]), 64'(g.crc));
      else timeout("crc_result");
    end
    gnt_rd  = gnt_q.size();
    done_rd = done_q.size();
    crc_rd  = crc_q.size();
    byte_rd = byte_q.size();
  endtask

  task automatic check_idle_outputs(input string name);
    check(name, {gnt, done, crc_out, busy, eng_rst, eng_en, eng_byte},
          {N_REQ'(0), N_REQ'(0), 16'h0, 1'b0, 1'b0, 1'b0, 8'h00});
  endtask

  typedef struct { int idx; logic [63:0] data; } vec_t;
  vec_t vecs[5];

  initial begin
    logic [63:0] word_a;
    vecs[0] = '{0, 64'h0123456789ABCDEF};
    vecs[1] = '{1, 64'hFEDCBA9876543210};
    vecs[2] = '{2, 64'h0000000000000000};
    vecs[3] = '{3, 64'hFFFFFFFFFFFFFFFF};
    vecs[4] = '{0, 64'hDEADBEEFCAFEF00D};

    rst = 1'b1;
    req = '0;
    data_in = '0;
    tick(3);
    rst = 1'b0;
    check_idle_outputs("reset_outputs");

    // Single jobs from the table.
    foreach (vecs[v]) begin
      set_word(vecs[v].idx, vecs[v].data);
      req = N_REQ'(1 << vecs[v].idx);
      wait_grants(1, 20);
      req = '0;
      wait_idle(40);
      if (v == 0) begin
        check("byte_count", 64'(byte_q.size() - byte_rd), 64'(NBYTES));
        for (int k = 0; k < NBYTES; k++) begin
          if (byte_rd + k < byte_q.size() && gnt_rd < gnt_q.size()) begin
            check("eng_byte", 64'(byte_q[byte_rd + k].b), 64'(vecs[v].data[63-8*k -: 8]));
            check("eng_byte_cycle", 64'(byte_q[byte_rd + k].cyc - gnt_q[gnt_rd].cyc), 64'(2 + k));
          end
        end
        check("crc_known_word", 64'(crc_out), 64'(golden(64'h0123456789ABCDEF)));
      end
      exp_q = {vecs[v].idx};
      check_jobs(1'b0);
    end

    // Contention: all four held, rotation 0,1,2,3,0 back to back.
    for (int i = 0; i < N_REQ; i++) set_word(i, {8{8'(8'h11 * (i + 1))}} ^ 64'h0F1E2D3C4B5A6978);
    wait_idle(5);
    exp_q = {};
    req = '1;
    // pointer is 0 after the last table job; force rotation to start from 0
    rst = 1'b1; tick(1); rst = 1'b0;
    wait_grants(5, 100);
    req = '0;
    wait_idle(40);
    exp_q = {0, 1, 2, 3, 0};
    check_jobs(1'b1);

    // Withdrawal: req[2] pulses for one cycle while requester 0 is served.
    set_word(0, 64'h1122334455667788);
    req = 4'b0001;
    wait_grants(1, 20);
    req = '0;
    tick(3);
    req = 4'b0100;
    tick(1);
    req = '0;
    wait_idle(40);
    check("withdraw_idle", 64'(busy), 64'(0));
    exp_q = {0};
    check_jobs(1'b0);

    // Fairness: req[1] held, req[3] rises mid-job; expect 1,3,1.
    set_word(1, 64'hA5A5A5A55A5A5A5A);
    set_word(3, 64'h0102030405060708);
    req = 4'b0010;
    wait_grants(1, 20);
    tick(4);
    req = 4'b1010;
    wait_grants(3, 60);
    req = '0;
    wait_idle(40);
    exp_q = {1, 3, 1};
    check_jobs(1'b1);

    // Reset mid-FEED: abort with no done, then pointer restarts at 0.
    set_word(0, 64'h8899AABBCCDDEEFF);
    set_word(1, 64'h7766554433221100);
    req = 4'b0010;
    wait_grants(1, 20);
    req = '0;
    tick(3);
    check("feeding_before_rst", 64'(eng_en), 64'(1));
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    check_idle_outputs("abort_outputs");
    tick(15);
    check("abort_no_done", 64'(done_q.size() - done_rd), 64'(0));
    gnt_rd  = gnt_q.size();
    crc_rd  = crc_q.size();
    byte_rd = byte_q.size();
    req = 4'b0011;
    wait_grants(2, 40);
    req = '0;
    wait_idle(40);
    exp_q = {0, 1};
    check_jobs(1'b1);

    // Data stability: word changes the cycle after gnt[0].
    word_a = 64'h0F0F0F0FF0F0F0F0;
    set_word(0, word_a);
    req = 4'b0001;
    wait_grants(1, 20);
    set_word(0, 64'h123456789ABCDEF0);
    req = '0;
    wait_idle(40);
    check("stable_crc", 64'(crc_out), 64'(golden(word_a)));
    exp_q = {0};
    check_jobs(1'b0);

    check("rst_en_overlap", 64'(overlap_cnt), 64'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
